sdram_init_seq: RTL

SDRAM power-up initialisation and periodic-refresh command generator, driving the SDRAM command pins on the sdram_clk side of the Wishbone-to-SDRAM bridge. After reset it issues the JEDEC sequence: power-up NOP wait, PRECHARGE-ALL, REF_COUNT AUTO-REFRESHes, LOAD MODE REGISTER. It then asserts init_done. From then on it schedules periodic AUTO-REFRESH requests that the bridge's command arbiter grants. Its pin outputs are what the team's SDRAM init checker observes.

---
 rtl/sdram_init_pkg.sv | 36 +++
 rtl/sdram_init_seq_delay_cnt.sv | 28 ++
 rtl/sdram_init_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sdram_init_pkg.sv
// Shared encodings and helpers for the SDRAM init/refresh sequencer.
// Commands are {cs_n, ras_n, cas_n, we_n}.
package sdram_init_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam int unsigned PRE_A10 = 10;
  localparam logic [2:0]  PEND_MAX = 3'd7;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_PRE,
    ST_WAIT_TRP,
    ST_REF,
    ST_WAIT_TRFC,
    ST_LMR,
    ST_WAIT_TMRD,
    ST_IDLE,
    ST_PREF,
    ST_PWAIT_TRFC
  } state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_init_seq_delay_cnt.sv
// Loadable down-counter used for command spacing; holds at zero.
module sdram_delay_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             one,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign one  = (cnt == WIDTH'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up init sequence and periodic auto-refresh scheduler.
// Command pins are registered from the next-state decode.
module sdram_init_seq
  import sdram_init_pkg::*;
#(
  parameter int unsigned           SDR_ADDR_W   = 13,
  parameter int unsigned           SDR_BA_W     = 2,
  parameter int unsigned           PWRUP_CYCLES = 10000,
  parameter int unsigned           TRP          = 3,
  parameter int unsigned           TRFC         = 7,
  parameter int unsigned           TMRD         = 2,
  parameter int unsigned           REF_COUNT    = 2,
  parameter int unsigned           REF_INTERVAL = 780,
  parameter logic [SDR_ADDR_W-1:0] MODE_REG     = SDR_ADDR_W'(13'h033)
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst_n,
  input  logic                  ref_gnt,
  output logic                  sdram_cs_n,
  output logic                  sdram_ras_n,
  output logic                  sdram_cas_n,
  output logic                  sdram_we_n,
  output logic [SDR_ADDR_W-1:0] sdram_addr,
  output logic [SDR_BA_W-1:0]   sdram_ba,
  output logic                  init_done,
  output logic                  ref_req,
  output logic                  ref_done,
  output logic                  ref_overflow
);

  localparam int unsigned CNT_W  = $clog2(max4(PWRUP_CYCLES, TRFC, TRP, TMRD)) + 1;
  localparam int unsigned REFS_W = $clog2(REF_COUNT + 1);
  localparam int unsigned IVAL_W = $clog2(REF_INTERVAL + 1);
  localparam bit          PWRUP_SHORT = (PWRUP_CYCLES <= 1);

  localparam logic [CNT_W-1:0]  PWRUP_LD   = CNT_W'(PWRUP_SHORT ? 0 : PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TRP_LD     = CNT_W'(TRP);
  localparam logic [CNT_W-1:0]  TRFC_LD    = CNT_W'(TRFC);
  localparam logic [CNT_W-1:0]  TMRD_LD    = CNT_W'(TMRD);
  localparam logic [IVAL_W-1:0] IVAL_LAST  = IVAL_W'(REF_INTERVAL - 1);

  state_e                  state, state_nxt;
  logic                    load, cnt_one, cnt_zero, issue, tick;
  logic [CNT_W-1:0]        load_val;
  logic [REFS_W-1:0]       refs_left;
  logic [IVAL_W-1:0]       ival;
  logic [2:0]              pending;
  logic [3:0]              cmd_nxt;
  logic [SDR_ADDR_W-1:0]   addr_nxt;

  sdram_delay_cnt #(.WIDTH(CNT_W)) u_delay (
    .clk      (sdram_clk),
    .rst_n    (sdram_rst_n),
    .load     (load),
    .load_val (load_val),
    .one      (cnt_one),
    .zero     (cnt_zero)
  );

  assign ref_req = (pending != '0) && (state == ST_IDLE);
  assign tick    = init_done && (ival == IVAL_LAST);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    issue     = 1'b0;
    unique case (state)
      // The counter is zero only on the first cycle out of reset; arm it there.
      ST_PWRUP: begin
        if (PWRUP_SHORT || cnt_one) begin
          state_nxt = ST_PRE;
          load      = 1'b1;
          load_val  = TRP_LD;
        end else if (cnt_zero) begin
          load     = 1'b1;
          load_val = PWRUP_LD;
        end
      end
      ST_PRE, ST_WAIT_TRP: begin
        if (cnt_one) begin
          state_nxt = ST_REF;
          load      = 1'b1;
          load_val  = TRFC_LD;
        end else begin
          state_nxt = ST_WAIT_TRP;
        end
      end
      ST_REF, ST_WAIT_TRFC: begin
        if (cnt_one) begin
          load = 1'b1;
          if (refs_left != '0) begin
            state_nxt = ST_REF;
            load_val  = TRFC_LD;
          end else begin
            state_nxt = ST_LMR;
            load_val  = TMRD_LD;
          end
        end else begin
          state_nxt = ST_WAIT_TRFC;
        end
      end
      ST_LMR, ST_WAIT_TMRD: state_nxt = cnt_one ? ST_IDLE : ST_WAIT_TMRD;
      ST_IDLE: begin
        if (ref_req && ref_gnt) begin
          issue     = 1'b1;
          state_nxt = ST_PREF;
          load      = 1'b1;
          load_val  = TRFC_LD;
        end
      end
      ST_PREF, ST_PWAIT_TRFC: state_nxt = cnt_one ? ST_IDLE : ST_PWAIT_TRFC;
      default: state_nxt = ST_PWRUP;
    endcase

    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    unique case (state_nxt)
      ST_PRE: begin
        cmd_nxt           = CMD_PRE;
        addr_nxt[PRE_A10] = 1'b1;
      end
      ST_REF, ST_PREF: cmd_nxt = CMD_REF;
      ST_LMR: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = MODE_REG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state      <= ST_PWRUP;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba   <= '0;
      init_done  <= 1'b0;
      ref_done   <= 1'b0;
      refs_left  <= '0;
    end else begin
      state      <= state_nxt;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_nxt;
      sdram_addr <= addr_nxt;
      sdram_ba   <= '0;
      if (state_nxt == ST_IDLE) init_done <= 1'b1;
      ref_done   <= ((state == ST_PREF) || (state == ST_PWAIT_TRFC)) && (state_nxt == ST_IDLE);
      if (state == ST_PWRUP) begin
        refs_left <= REFS_W'(REF_COUNT);
      end else if (state_nxt == ST_REF) begin
        refs_left <= refs_left - 1'b1;
      end
    end
  end

  // Overflow flags any tick landing on a full count, even when a grant absorbs it.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      ival         <= '0;
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else if (init_done) begin
      ival <= tick ? '0 : ival + 1'b1;
      if (tick && (pending == PEND_MAX)) ref_overflow <= 1'b1;
      if (tick && !issue) begin
        if (pending != PEND_MAX) pending <= pending + 1'b1;
      end else if (issue && !tick) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule
